vx_branch_resolve_unit: RTL and testbench

// - Scheduler-side receiver of the per-block branch control outputs produced by the ALU execute blocks.
// - Buffers branch resolutions arriving concurrently from NUM_BLOCKS blocks, which have no ready/backpressure.
// - Serializes them into one PC-update stream to the warp scheduler.
// - Tracks a per-warp branch-pending mask, used by the scheduler to stall warps.

---
 rtl/VX_gpu_pkg.sv | 17 +
 rtl/vx_branch_rsp_fifo.sv | 54 +++++
 rtl/vx_branch_resolve_unit.sv | 115 +++++++++++
 tb/tb_vx_branch_resolve_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared GPU core types: branch response record and the core-level sizing defaults.
package VX_gpu_pkg;

  localparam int CFG_NUM_BLOCKS = 2;
  localparam int CFG_NUM_WARPS  = 8;
  localparam int NW_WIDTH       = 3;
  localparam int PC_WIDTH       = 32;

  typedef struct packed {
    logic [NW_WIDTH-1:0] wid;
    logic                taken;
    logic [PC_WIDTH-1:0] dest;
  } branch_rsp_t;

  localparam int BRANCH_RSP_W = $bits(branch_rsp_t);

endpackage

// File: rtl/vx_branch_rsp_fifo.sv
// Per-block branch response FIFO; an empty FIFO presents its push data
// combinationally so a lone resolution reaches the output register next cycle.
module vx_branch_rsp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, bypass, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // pushed and consumed in the same cycle: never stored
  assign bypass  = empty && push && pop;
  assign do_push = push && !bypass;
  assign do_pop  = pop && !empty;
  assign valid   = !empty || push;
  assign dout    = empty ? din : mem[rd_ptr];

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && full));
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/vx_branch_resolve_unit.sv
// Collects branch resolutions from all ALU blocks, serializes them round-robin
// into one PC-update stream and tracks per-warp pending branches.
// Optional perf counters enabled by defining VX_BRANCH_PERF_EN.
module vx_branch_resolve_unit
  import VX_gpu_pkg::*;
#(
  parameter int NUM_BLOCKS = CFG_NUM_BLOCKS,
  parameter int NUM_WARPS  = CFG_NUM_WARPS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_BLOCKS-1:0]          br_valid_in,
  input  logic [NUM_BLOCKS*NW_WIDTH-1:0] br_wid_in,
  input  logic [NUM_BLOCKS-1:0]          br_taken_in,
  input  logic [NUM_BLOCKS*PC_WIDTH-1:0] br_dest_in,
  input  logic                           issue_valid,
  input  logic [NW_WIDTH-1:0]            issue_wid,
  output logic                           upd_valid,
  output logic [NW_WIDTH-1:0]            upd_wid,
  output logic                           upd_taken,
  output logic [PC_WIDTH-1:0]            upd_pc,
  input  logic                           upd_ready,
  output logic [NUM_WARPS-1:0]           pending_mask
`ifdef VX_BRANCH_PERF_EN
  ,
  output logic [63:0]                    perf_taken,
  output logic [63:0]                    perf_not_taken
`endif
);
  localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

  branch_rsp_t [NUM_BLOCKS-1:0] head;
  logic [NUM_BLOCKS-1:0]        head_valid, pop;
  logic [BW-1:0]                rr_ptr, sel;
  logic                         sel_found, load, fire;
  logic [NUM_WARPS-1:0]         set_mask, clr_mask;

  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
    branch_rsp_t rsp_in;
    assign rsp_in = '{wid:   br_wid_in[i*NW_WIDTH +: NW_WIDTH],
                      taken: br_taken_in[i],
                      dest:  br_dest_in[i*PC_WIDTH +: PC_WIDTH]};

    vx_branch_rsp_fifo #(.W(BRANCH_RSP_W), .DEPTH(NUM_WARPS)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (br_valid_in[i]),
      .din   (rsp_in),
      .pop   (pop[i]),
      .valid (head_valid[i]),
      .dout  (head[i])
    );
  end

  // Walk from the farthest candidate back to rr_ptr so the nearest valid wins.
  always_comb begin
    int            k;
    logic [BW-1:0] kk;
    sel       = rr_ptr;
    sel_found = 1'b0;
    k         = 0;
    kk        = '0;
    for (int j = NUM_BLOCKS-1; j >= 0; j--) begin
      k = int'(rr_ptr) + j;
      if (k >= NUM_BLOCKS) k = k - NUM_BLOCKS;
      kk = BW'(k);
      if (head_valid[kk]) begin
        sel       = kk;
        sel_found = 1'b1;
      end
    end
  end

  assign fire     = upd_valid && upd_ready;
  assign load     = sel_found && (!upd_valid || upd_ready);
  assign pop      = load ? (NUM_BLOCKS'(1) << sel) : '0;
  assign set_mask = issue_valid ? (NUM_WARPS'(1) << issue_wid) : '0;
  assign clr_mask = fire ? (NUM_WARPS'(1) << upd_wid) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid    <= 1'b0;
      upd_wid      <= '0;
      upd_taken    <= 1'b0;
      upd_pc       <= '0;
      rr_ptr       <= '0;
      pending_mask <= '0;
    end else begin
      // a warp may re-issue in the very cycle its previous branch retires
      assert (!(issue_valid && pending_mask[issue_wid] && !(fire && upd_wid == issue_wid)));
      if (load) begin
        upd_valid <= 1'b1;
        upd_wid   <= head[sel].wid;
        upd_taken <= head[sel].taken;
        upd_pc    <= head[sel].dest;
        rr_ptr    <= (sel == BW'(NUM_BLOCKS-1)) ? '0 : sel + 1'b1;
      end else if (upd_ready) begin
        upd_valid <= 1'b0;
      end
      pending_mask <= (pending_mask & ~clr_mask) | set_mask;
    end
  end

`ifdef VX_BRANCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_taken     <= '0;
      perf_not_taken <= '0;
    end else if (fire) begin
      if (upd_taken) perf_taken     <= perf_taken + 64'd1;
      else           perf_not_taken <= perf_not_taken + 64'd1;
    end
  end
`endif
endmodule

// File: tb/tb_vx_branch_resolve_unit.sv
// Directed + randomized bench for vx_branch_resolve_unit against a queue-based
// reference model; perf counters checked when VX_BRANCH_PERF_EN is defined.
module tb_vx_branch_resolve_unit;
  import VX_gpu_pkg::*;

  localparam int NB    = 2;
  localparam int NWARP = 8;

  typedef struct {
    logic [NW_WIDTH-1:0] wid;
    logic                taken;
    logic [PC_WIDTH-1:0] dest;
  } rsp_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NB-1:0]             br_valid_in, br_taken_in;
  logic [NB*NW_WIDTH-1:0]    br_wid_in;
  logic [NB*PC_WIDTH-1:0]    br_dest_in;
  logic                      issue_valid, upd_ready;
  logic [NW_WIDTH-1:0]       issue_wid;
  logic                      upd_valid, upd_taken;
  logic [NW_WIDTH-1:0]       upd_wid;
  logic [PC_WIDTH-1:0]       upd_pc;
  logic [NWARP-1:0]          pending_mask;
`ifdef VX_BRANCH_PERF_EN
  logic [63:0]               perf_taken, perf_not_taken;
`endif

  vx_branch_resolve_unit #(.NUM_BLOCKS(NB), .NUM_WARPS(NWARP)) dut (
    .clk          (clk),
    .reset        (reset),
    .br_valid_in  (br_valid_in),
    .br_wid_in    (br_wid_in),
    .br_taken_in  (br_taken_in),
    .br_dest_in   (br_dest_in),
    .issue_valid  (issue_valid),
    .issue_wid    (issue_wid),
    .upd_valid    (upd_valid),
    .upd_wid      (upd_wid),
    .upd_taken    (upd_taken),
    .upd_pc       (upd_pc),
    .upd_ready    (upd_ready),
    .pending_mask (pending_mask)
`ifdef VX_BRANCH_PERF_EN
    ,
    .perf_taken     (perf_taken),
    .perf_not_taken (perf_not_taken)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus for the next cycle
  logic [NB-1:0]       s_v, s_t;
  logic [NW_WIDTH-1:0] s_w [NB];
  logic [PC_WIDTH-1:0] s_d [NB];
  logic                s_iv, s_rdy, s_rst;
  logic [NW_WIDTH-1:0] s_iw;

  // reference model
  rsp_t                q [NB][$];
  logic                m_valid, m_taken;
  logic [NW_WIDTH-1:0] m_wid;
  logic [PC_WIDTH-1:0] m_pc;
  int                  m_rr;
  logic [NWARP-1:0]    m_mask;
  longint unsigned     m_pt, m_pnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    s_v = '0; s_t = '0; s_iv = 1'b0; s_iw = '0; s_rdy = 1'b1; s_rst = 1'b0;
    for (int b = 0; b < NB; b++) begin s_w[b] = '0; s_d[b] = '0; end
  endtask

  task automatic br(input int b, input logic [NW_WIDTH-1:0] w, input logic t, input logic [PC_WIDTH-1:0] d);
    s_v[b] = 1'b1; s_w[b] = w; s_t[b] = t; s_d[b] = d;
  endtask

  task automatic iss(input logic [NW_WIDTH-1:0] w);
    s_iv = 1'b1; s_iw = w;
  endtask

  task automatic model_step();
    logic             fire, found;
    logic [NWARP-1:0] nmask;
    rsp_t             r;
    int               k;
    if (s_rst) begin
      for (int b = 0; b < NB; b++) q[b].delete();
      m_valid = 0; m_wid = '0; m_taken = 0; m_pc = '0; m_rr = 0; m_mask = '0;
      m_pt = 0; m_pnt = 0;
      return;
    end
    fire = m_valid && s_rdy;
    if (fire) begin
      if (m_taken) m_pt++; else m_pnt++;
    end
    for (int b = 0; b < NB; b++)
      if (s_v[b]) q[b].push_back('{s_w[b], s_t[b], s_d[b]});
    nmask = m_mask;
    if (fire) nmask[m_wid] = 1'b0;
    if (s_iv) nmask[s_iw] = 1'b1;
    if (!m_valid || s_rdy) begin
      found = 0;
      for (int j = 0; j < NB && !found; j++) begin
        k = (m_rr + j) % NB;
        if (q[k].size() > 0) begin
          r = q[k].pop_front();
          m_valid = 1; m_wid = r.wid; m_taken = r.taken; m_pc = r.dest;
          m_rr = (k + 1) % NB;
          found = 1;
        end
      end
      if (!found) m_valid = 0;
    end
    m_mask = nmask;
  endtask

  task automatic step();
    br_valid_in = s_v;
    br_taken_in = s_t;
    for (int b = 0; b < NB; b++) begin
      br_wid_in[b*NW_WIDTH +: NW_WIDTH]  = s_w[b];
      br_dest_in[b*PC_WIDTH +: PC_WIDTH] = s_d[b];
    end
    issue_valid = s_iv; issue_wid = s_iw; upd_ready = s_rdy; reset = s_rst;
    model_step();
    @(posedge clk);
    #1;
    check("upd_valid", 64'(upd_valid), 64'(m_valid));
    check("upd_wid", 64'(upd_wid), 64'(m_wid));
    check("upd_taken", 64'(upd_taken), 64'(m_taken));
    check("upd_pc", 64'(upd_pc), 64'(m_pc));
    check("pending_mask", 64'(pending_mask), 64'(m_mask));
`ifdef VX_BRANCH_PERF_EN
    check("perf_taken", perf_taken, m_pt);
    check("perf_not_taken", perf_not_taken, m_pnt);
`endif
    clr();
  endtask

  int inflight[$];
  int idx, w;

  initial begin
    clr();
    // reset state
    s_rst = 1; step();
    check("rst_valid", 64'(upd_valid), 64'd0);
    check("rst_mask", 64'(pending_mask), 64'd0);

    // single branch
    iss(3); step();
    check("single_pend", 64'(pending_mask[3]), 64'd1);
    br(0, 3, 1, 32'h8000_0100); step();
    check("single_valid", 64'(upd_valid), 64'd1);
    check("single_wid", 64'(upd_wid), 64'd3);
    check("single_pc", 64'(upd_pc), 64'h8000_0100);
    step();
    check("single_clear", 64'(pending_mask[3]), 64'd0);

    // collisions
    s_rst = 1; step();
    iss(1); step(); iss(2); step(); iss(5); step(); iss(6); step();
    br(0, 1, 1, 32'h100); br(1, 2, 0, 32'h200); step();
    check("coll_first", 64'(upd_wid), 64'd1);
    br(0, 5, 1, 32'h500); br(1, 6, 1, 32'h600); step();
    check("coll_second", 64'(upd_wid), 64'd2);
    step(); step(); step();

    // backpressure
    iss(0); step(); iss(3); step(); iss(7); step();
    s_rdy = 0; br(0, 0, 1, 32'hA0); br(1, 3, 1, 32'hA3); step();
    s_rdy = 0; br(0, 7, 0, 32'hA7); step();
    for (int c = 0; c < 5; c++) begin
      s_rdy = 0; step();
      check("bp_hold_wid", 64'(upd_wid), 64'd0);
      check("bp_hold_pc", 64'(upd_pc), 64'hA0);
    end
    step(); check("bp_fire2", 64'(upd_wid), 64'd3);
    step(); check("bp_fire3", 64'(upd_wid), 64'd7);
    step(); check("bp_empty", 64'(upd_valid), 64'd0);

    // same-cycle set/clear
    iss(4); step();
    br(1, 4, 1, 32'h44); step();
    iss(4); step();
    check("setclr_mask", 64'(pending_mask[4]), 64'd1);
    br(0, 4, 0, 32'h48); step(); step();
    check("setclr_done", 64'(pending_mask[4]), 64'd0);

    // reset mid-drain
    iss(1); step(); iss(2); step(); iss(3); step();
    s_rdy = 0; br(0, 1, 1, 32'h11); br(1, 2, 1, 32'h22); step();
    s_rdy = 0; br(0, 3, 1, 32'h33); step();
    s_rst = 1; step();
    check("rstmid_valid", 64'(upd_valid), 64'd0);
    check("rstmid_mask", 64'(pending_mask), 64'd0);
    for (int c = 0; c < 4; c++) begin
      step(); check("rstmid_stale", 64'(upd_valid), 64'd0);
    end

`ifdef VX_BRANCH_PERF_EN
    s_rst = 1; step();
    for (int i = 0; i < 6; i++) begin iss(NW_WIDTH'(i)); step(); end
    br(0, 0, 1, 32'h10); br(1, 1, 1, 32'h14); step();
    br(0, 2, 1, 32'h18); br(1, 4, 0, 32'h1C); step();
    br(0, 3, 1, 32'h20); br(1, 5, 0, 32'h24); step();
    for (int c = 0; c < 6; c++) step();
    check("perf_taken_4", perf_taken, 64'd4);
    check("perf_not_taken_2", perf_not_taken, 64'd2);
`endif

    // randomized traffic obeying one branch per warp
    s_rst = 1; step();
    for (int c = 0; c < 500; c++) begin
      s_rdy = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < NB; b++) begin
        if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
          idx = $urandom_range(0, inflight.size() - 1);
          br(b, NW_WIDTH'(inflight[idx]), 1'($urandom_range(0, 1)), $urandom);
          inflight.delete(idx);
        end
      end
      if ($urandom_range(0, 2) != 0) begin
        w = $urandom_range(0, NWARP - 1);
        if (!m_mask[w]) begin
          iss(NW_WIDTH'(w));
          inflight.push_back(w);
        end
      end
      step();
    end
    for (int c = 0; c < 20; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
